// File: rtl/vga_fb_pkg.sv
// Shared types and width constants for the VGA frame-buffer responder.
// The fetch FSM state type lives here so the bench and RTL agree on names.
package vga_fb_pkg;

    localparam int VGA_ADDR_W = 20;
    localparam int VGA_DATA_W = 48;
    localparam int MEM_ADDR_W = 21;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_VALID,
        ST_GAP
    } fb_state_t;

endpackage

// File: rtl/vga_offset_buf.sv
// Double-buffered frame offset: the CPU writes the pending copy, and the
// frame-boundary strobe promotes it to the active copy seen by the scanner.
module vga_offset_buf #(
    parameter int W = vga_fb_pkg::VGA_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ctrl_we,
    input  logic [W-1:0] ctrl_wdata,
    input  logic         offset_sel,
    output logic [W-1:0] offset
);

    logic [W-1:0] pend_reg;
    logic [W-1:0] act_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg <= '0;
            act_reg  <= '0;
        end else begin
            if (ctrl_we) begin
                pend_reg <= ctrl_wdata;
            end
            // A write landing on the frame boundary goes straight to the active copy.
            if (offset_sel) begin
                act_reg <= ctrl_we ? ctrl_wdata : pend_reg;
            end
        end
    end

    assign offset = act_reg;

endmodule

// File: rtl/vga_fb_responder.sv
// Serves one 48-bit pixel-group fetch with two 32-bit memory reads and
// owns the double-buffered frame offset handed back to the scanner.
module vga_fb_responder #(
    parameter int VGA_ADDR_W = vga_fb_pkg::VGA_ADDR_W,
    parameter int VGA_DATA_W = vga_fb_pkg::VGA_DATA_W,
    parameter int MEM_ADDR_W = vga_fb_pkg::MEM_ADDR_W,
    parameter int MEM_DATA_W = vga_fb_pkg::MEM_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vga_sel,
    input  logic [VGA_ADDR_W-1:0] vga_addr,
    output logic [VGA_DATA_W-1:0] vga_data,
    output logic                  vga_valid,
    input  logic                  vga_offset_sel,
    output logic [VGA_ADDR_W-1:0] vga_offset_in,
    input  logic                  ctrl_we,
    input  logic [VGA_ADDR_W-1:0] ctrl_wdata,
    output logic                  mem_req,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [MEM_DATA_W-1:0] mem_rdata
);

    import vga_fb_pkg::*;

    localparam int HI_W = VGA_DATA_W - MEM_DATA_W;

    fb_state_t             state_reg;
    fb_state_t             state_next;
    logic [VGA_ADDR_W-1:0] addr_reg;
    logic [MEM_DATA_W-1:0] w0_reg;
    logic [HI_W-1:0]       w1_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            w0_reg    <= '0;
            w1_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && vga_sel) begin
                addr_reg <= vga_addr;
            end
            if (state_reg == ST_RD0 && mem_ack) begin
                w0_reg <= mem_rdata;
            end
            // Only the low pixel bits of the second word belong to the group.
            if (state_reg == ST_RD1 && mem_ack) begin
                w1_reg <= mem_rdata[HI_W-1:0];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        vga_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (vga_sel) begin
                    state_next = ST_RD0;
                end
            end
            ST_RD0: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_next = ST_RD1;
                end
            end
            ST_RD1: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_next = ST_VALID;
                end
            end
            ST_VALID: begin
                vga_valid  = 1'b1;
                state_next = ST_GAP;
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Word address is the group index doubled; the low bit picks the half.
    assign mem_addr = {addr_reg, state_reg == ST_RD1};
    assign vga_data = {w1_reg, w0_reg};

    vga_offset_buf #(
        .W(VGA_ADDR_W)
    ) u_offset_buf (
        .clk        (clk),
        .rst        (rst),
        .ctrl_we    (ctrl_we),
        .ctrl_wdata (ctrl_wdata),
        .offset_sel (vga_offset_sel),
        .offset     (vga_offset_in)
    );

endmodule

// File: tb/tb_vga_fb_responder.sv
// Directed plus randomized bench for vga_fb_responder with a memory model
// that inserts configurable wait states and a reference for expected data.
module tb_vga_fb_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_sel;
    logic [19:0] vga_addr;
    logic [47:0] vga_data;
    logic        vga_valid;
    logic        vga_offset_sel;
    logic [19:0] vga_offset_in;
    logic        ctrl_we;
    logic [19:0] ctrl_wdata;
    logic        mem_req;
    logic [20:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    int          wait_n   = 0;
    bit          model_on = 1'b1;
    logic        model_ack   = 1'b0;
    logic        stray_ack   = 1'b0;
    logic [31:0] model_rdata = '0;
    logic [31:0] salt        = '0;
    logic [20:0] ack_log[$];

    assign mem_ack   = model_ack | stray_ack;
    assign mem_rdata = model_rdata;

    always #5 clk = ~clk;

    vga_fb_responder dut (
        .clk            (clk),
        .rst            (rst),
        .vga_sel        (vga_sel),
        .vga_addr       (vga_addr),
        .vga_data       (vga_data),
        .vga_valid      (vga_valid),
        .vga_offset_sel (vga_offset_sel),
        .vga_offset_in  (vga_offset_in),
        .ctrl_we        (ctrl_we),
        .ctrl_wdata     (ctrl_wdata),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    function automatic logic [31:0] mem_word(input logic [20:0] n);
        if (salt == 32'h0) return 32'hA500_0000 | {11'b0, n};
        return ({11'b0, n} * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic logic [47:0] exp_data(input logic [19:0] a);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = mem_word({a, 1'b0});
        hi = mem_word({a, 1'b1});
        return {hi[15:0], lo};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory: acks after wait_n stalled cycles of each request.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            model_ack = 1'b0;
            if (rst || !model_on || !mem_req) begin
                cnt = 0;
            end else if (cnt >= wait_n) begin
                model_ack   = 1'b1;
                model_rdata = mem_word(mem_addr);
                cnt = 0;
            end else begin
                cnt++;
            end
        end
    end

    // Log every read the DUT actually consumes.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst && mem_req && mem_ack) ack_log.push_back(mem_addr);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(output int lat, output int reqs);
        lat  = 0;
        reqs = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (mem_req) reqs++;
            if (vga_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_reads(input string tag, input logic [19:0] a);
        check({tag, " reads"}, ack_log.size(), 2);
        if (ack_log.size() >= 2) begin
            check({tag, " addr0"}, ack_log[0], {a, 1'b0});
            check({tag, " addr1"}, ack_log[1], {a, 1'b1});
        end
    endtask

    task automatic fetch(input logic [19:0] a, input int w, input string tag);
        int lat;
        int reqs;
        logic [47:0] d;
        @(negedge clk);
        wait_n   = w;
        vga_sel  = 1'b1;
        vga_addr = a;
        ack_log.delete();
        wait_valid(lat, reqs);
        d = vga_data;
        vga_sel = 1'b0;
        $display("fetch %s addr=0x%05h wait=%0d latency=%0d data=0x%012h", tag, a, w, lat, d);
        check({tag, " latency"}, lat, 3 + 2 * w);
        check({tag, " req cycles"}, reqs, 2 + 2 * w);
        check({tag, " data"}, d, exp_data(a));
        check_reads(tag, a);
        @(negedge clk);
        check({tag, " valid pulse"}, vga_valid, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int reqs;
        int seen;
        logic [19:0] pend_m;
        logic [19:0] act_m;
        logic [19:0] ra;
        logic        we_r;
        logic        sel_r;
        logic [19:0] wd_r;

        rst = 1'b1;
        vga_sel = 1'b0;
        vga_addr = '0;
        vga_offset_sel = 1'b0;
        ctrl_we = 1'b0;
        ctrl_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst mem_req", mem_req, 1'b0);
        check("rst mem_addr", mem_addr, 21'h0);
        check("rst vga_valid", vga_valid, 1'b0);
        check("rst vga_data", vga_data, 48'h0);
        check("rst offset", vga_offset_in, 20'h0);
        rst = 1'b0;

        // Pending copy must come out of reset as zero.
        vga_offset_sel = 1'b1;
        @(negedge clk);
        vga_offset_sel = 1'b0;
        check("pend reset", vga_offset_in, 20'h0);

        fetch(20'h00005, 0, "zero-wait");
        check("zero-wait const", exp_data(20'h00005), 48'h000B_A500_000A);
        fetch(20'h00005, 3, "wait-3");
        fetch(20'hFFFFF, 0, "top");

        // Back-to-back: request held through GAP with a new address.
        @(negedge clk);
        wait_n = 0;
        vga_sel = 1'b1;
        vga_addr = 20'h00010;
        ack_log.delete();
        wait_valid(lat, reqs);
        $display("b2b first latency=%0d data=0x%012h", lat, vga_data);
        check("b2b first latency", lat, 3);
        check("b2b first data", vga_data, exp_data(20'h00010));
        vga_addr = 20'h00011;
        ack_log.delete();
        wait_valid(lat, reqs);
        vga_sel = 1'b0;
        $display("b2b second latency=%0d data=0x%012h", lat, vga_data);
        check("b2b throughput", lat, 5);
        check("b2b second data", vga_data, exp_data(20'h00011));
        check_reads("b2b second", 20'h00011);
        repeat (2) @(negedge clk);

        // Offset ordering.
        ctrl_we = 1'b1;
        ctrl_wdata = 20'h12345;
        @(negedge clk);
        ctrl_we = 1'b0;
        check("offset before sel", vga_offset_in, 20'h0);
        repeat (2) @(negedge clk);
        check("offset still held", vga_offset_in, 20'h0);
        vga_offset_sel = 1'b1;
        @(negedge clk);
        vga_offset_sel = 1'b0;
        $display("offset after sel = 0x%05h", vga_offset_in);
        check("offset after sel", vga_offset_in, 20'h12345);
        ctrl_we = 1'b1;
        ctrl_wdata = 20'h00ABC;
        vga_offset_sel = 1'b1;
        @(negedge clk);
        ctrl_we = 1'b0;
        vga_offset_sel = 1'b0;
        $display("offset simultaneous = 0x%05h", vga_offset_in);
        check("offset simultaneous", vga_offset_in, 20'h00ABC);

        // Random offset traffic against a pending/active model.
        pend_m = 20'h00ABC;
        act_m  = 20'h00ABC;
        for (int i = 0; i < 16; i++) begin
            we_r  = 1'($urandom_range(0, 1));
            sel_r = 1'($urandom_range(0, 1));
            wd_r  = 20'($urandom);
            ctrl_we = we_r;
            ctrl_wdata = wd_r;
            vga_offset_sel = sel_r;
            @(negedge clk);
            if (sel_r) act_m = we_r ? wd_r : pend_m;
            if (we_r) pend_m = wd_r;
            $display("offset step %0d we=%0b sel=%0b wdata=0x%05h out=0x%05h", i, we_r, sel_r, wd_r, vga_offset_in);
            check("offset random", vga_offset_in, act_m);
        end
        ctrl_we = 1'b0;
        vga_offset_sel = 1'b0;

        // Reset while in RD1, then a late ack for the aborted read.
        model_on = 1'b0;
        @(negedge clk);
        vga_sel = 1'b1;
        vga_addr = 20'h00077;
        @(negedge clk);
        check("abort rd0 req", mem_req, 1'b1);
        check("abort rd0 addr", mem_addr, {20'h00077, 1'b0});
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        check("abort rd1 addr", mem_addr, {20'h00077, 1'b1});
        rst = 1'b1;
        vga_sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort req after rst", mem_req, 1'b0);
        stray_ack = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            stray_ack = 1'b0;
            if (vga_valid || mem_req) seen++;
        end
        $display("abort activity after stray ack = %0d", seen);
        check("abort no activity", seen, 0);
        model_on = 1'b1;
        fetch(20'h00077, 1, "post-reset");

        // Randomized fetches with a scrambled memory image.
        salt = $urandom | 32'h1;
        for (int i = 0; i < 8; i++) begin
            ra = 20'($urandom);
            fetch(ra, int'($urandom_range(0, 3)), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
